wb_active_ctrl: RTL
===================

WB_ACTIVE_CTRL -- requirements
Module: wb_active_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the Wishbone base address of the register window.
REQ-002 SHALL have parameter RESET_GUARD, default 8'd8, giving the reset value of GUARD.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, each input, 1 bit: Wishbone strobe, cycle and write enable.
REQ-006 SHALL have port wbs_sel_i, input, 4 bits: write byte enables.
REQ-007 SHALL have ports wbs_adr_i and wbs_dat_i, each input, 32 bits: address and write data.
REQ-008 SHALL have port wbs_ack_o, output, 1 bit, and port wbs_dat_o, output, 32 bits: acknowledge and read data.
REQ-009 SHALL have port active, output, 32 bits: one-hot project enable vector, driving the active inputs of the project instances.
REQ-010 SHALL have port switch_done, output, 1 bit: one-cycle pulse when a project switch completes.

Function
REQ-011 Register window = BASE_ADDR..BASE_ADDR+0xFF; decode on wbs_adr_i[7:0].
- Outside the window: no ack; wbs_dat_o = 0.
- Unmapped offsets inside the window: write ignored, read 0, still acked.
REQ-012 Offset 0x00 SEL, RW, reset 0.
- bits[4:0] = project index; bit[31] = enable.
- Other bits read 0.
REQ-013 Offset 0x04 GUARD, RW, bits[7:0], reset RESET_GUARD: number of all-zero drain cycles.
REQ-014 Offset 0x08 STATUS, RO.
- bit0 = busy (state DRAIN).
- bits[12:8] = applied index; bit16 = applied enable.
- bits[31:24] = switch counter, wraps 255->0.
- Writes ignored.
REQ-015 Writes honour wbs_sel_i per byte; disabled bytes keep their old value.
REQ-016 Handshake: wbs_ack_o rises the cycle after stb&cyc is seen in-window with ack low, and is high for exactly one cycle.
- A request held across the ack cycle is not acked twice.
- Read data is valid in the ack cycle.
- A write takes effect in the ack cycle.
REQ-017 FSM states: IDLE, DRAIN.
REQ-018 IDLE -> DRAIN on an acked SEL write whose {enable,index} differs from the applied value.
- On entry: active <= 0; drain counter <= GUARD.
- A write with the same value causes no transition and no pulse.
REQ-019 In DRAIN, the counter decrements each cycle. When the counter is 0 (GUARD=0 gives exactly one all-zero cycle), next cycle:
- active <= enable ? (1<<index) : 0;
- applied value updated;
- switch counter incremented;
- switch_done pulses;
- return to IDLE.
REQ-020 A SEL write during DRAIN SHALL reload the drain counter from GUARD and retarget to the new value; only one switch_done pulse results.
REQ-021 A GUARD write during DRAIN SHALL affect only later drains.
REQ-022 active SHALL never have more than one bit set, and SHALL never go directly from one non-zero value to a different non-zero value.

Reset
REQ-023 On wb_rst_i high at a clock edge, all of the following clear, including mid-drain and mid-transaction:
- active = 0, wbs_ack_o = 0, wbs_dat_o = 0, switch_done = 0;
- SEL = 0, GUARD = RESET_GUARD, switch counter = 0;
- state = IDLE.

Configuration
REQ-024 Macro ACTIVE_LA_OVERRIDE_EN, when defined, SHALL add two inputs: la_override (1 bit) and la_active (32 bits).
- While la_override = 1, active = la_active (combinational; no one-hot check); the FSM keeps running internally.
- STATUS bit17 = la_override.
- Without the macro: these ports are absent, bit17 reads 0, and active is FSM-only.

Verification
REQ-025 Reset, then read 0x08 -> 0x0000_0000; read 0x04 -> 0x08; active = 0.
REQ-026 Write SEL = 0x8000_0003 with GUARD = 8 -> active = 0 for 9 cycles, then 0x0000_0008; switch_done pulses once; STATUS[31:24] = 1.
REQ-027 Write SEL = 0x8000_0003 again -> no drain, no pulse, active unchanged.
REQ-028 Write SEL = 0x8000_0005, then write SEL = 0x8000_0007 four cycles later -> the drain restarts; final active = 0x80; exactly one pulse.
REQ-029 Assert reset mid-drain -> the next cycle matches REQ-025; byte-enable write 0x04 with sel = 4'b0010 -> GUARD unchanged.
REQ-030 With ACTIVE_LA_OVERRIDE_EN: la_override = 1, la_active = 0xF0 -> active = 0xF0 the same cycle; release -> the FSM value is restored.

Source files
------------

// File: rtl/wb_active_ctrl_if.sv
// ---------------------------------------------------------------------------
// wb_active_ctrl_if
// Purpose : Wishbone slave bus bundle for wb_active_ctrl (classic single
//           transfer: strobe/cycle in, single-cycle acknowledge out).
// Signals : wbs_stb_i, wbs_cyc_i, wbs_we_i  - strobe, cycle, write enable
//           wbs_sel_i[3:0]                  - write byte enables
//           wbs_adr_i[31:0], wbs_dat_i[31:0]- address, write data
//           wbs_ack_o, wbs_dat_o[31:0]      - acknowledge, read data
// Modports: master (bus initiator), slave (the controller).
// ---------------------------------------------------------------------------
interface wb_active_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_active_ctrl.sv
// ---------------------------------------------------------------------------
// wb_active_ctrl
// Purpose : Wishbone-controlled one-hot project enable. Selecting a new
//           project first drives `active` to all-zero for GUARD+1 cycles
//           (drain), then enables the chosen project and pulses switch_done.
// Ports   : wb_clk_i      - clock, rising edge
//           wb_rst_i      - synchronous active-high reset
//           wbs           - Wishbone slave bundle (wb_active_ctrl_if.slave)
//           la_override, la_active - only when ACTIVE_LA_OVERRIDE_EN is
//                           defined: direct combinational override of active
//           active[31:0]  - one-hot project enable
//           switch_done   - one-cycle pulse when a switch completes
// Registers (offset from BASE_ADDR):
//           0x00 SEL    [31]=enable, [4:0]=project index
//           0x04 GUARD  [7:0] drain length
//           0x08 STATUS [0]=busy [12:8]=applied index [16]=applied enable
//                       [17]=la_override [31:24]=switch counter (RO)
// Option  : define ACTIVE_LA_OVERRIDE_EN to add the logic-analyser override.
// ---------------------------------------------------------------------------
module wb_active_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [7:0]  RESET_GUARD = 8'd8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_active_ctrl_if.slave       wbs,
`ifdef ACTIVE_LA_OVERRIDE_EN
    input  logic                  la_override,
    input  logic [31:0]           la_active,
`endif
    output logic [31:0]           active,
    output logic                  switch_done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_sel_en;
    logic [4:0]  r_sel_idx;
    logic [7:0]  r_guard;
    logic        r_app_en;
    logic [4:0]  r_app_idx;
    logic [7:0]  r_cnt;
    logic [7:0]  r_sw_cnt;
    logic [31:0] r_active;
    logic        r_done;
    logic        r_ack;
    logic [31:0] r_dat;

    logic        w_in_win;
    logic        w_req;
    logic        w_wr;
    logic [7:0]  w_off;
    logic        w_sel_wr;
    logic        w_guard_wr;
    logic        w_new_en;
    logic [4:0]  w_new_idx;
    logic [7:0]  w_new_guard;
    logic        w_ovr;
    logic [31:0] w_status;
    logic [31:0] w_rd_data;
    logic [31:0] w_onehot;
    logic        w_unused;

    // Window is the 256-byte page holding BASE_ADDR.
    assign w_in_win = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Masking with r_ack keeps a request held through its ack from being
    // accepted again in the ack cycle.
    assign w_req    = wbs.wbs_stb_i & wbs.wbs_cyc_i & w_in_win & ~r_ack;
    assign w_wr     = w_req & wbs.wbs_we_i;
    assign w_off    = wbs.wbs_adr_i[7:0];
    assign w_sel_wr   = w_wr && (w_off == 8'h00);
    assign w_guard_wr = w_wr && (w_off == 8'h04);

    // Byte-lane merge: only lanes 0 and 3 carry SEL fields.
    assign w_new_en    = wbs.wbs_sel_i[3] ? wbs.wbs_dat_i[31]  : r_sel_en;
    assign w_new_idx   = wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[4:0] : r_sel_idx;
    assign w_new_guard = wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[7:0] : r_guard;

    assign w_unused = ^{wbs.wbs_dat_i[30:8]};

`ifdef ACTIVE_LA_OVERRIDE_EN
    assign w_ovr  = la_override;
    assign active = la_override ? la_active : r_active;
`else
    assign w_ovr  = 1'b0;
    assign active = r_active;
`endif

    assign w_status = {r_sw_cnt, 6'd0, w_ovr, r_app_en, 3'd0, r_app_idx,
                       7'd0, (r_state == S_DRAIN)};

    always_comb begin
        w_rd_data = 32'd0;
        case (w_off)
            8'h00:   w_rd_data = {r_sel_en, 26'd0, r_sel_idx};
            8'h04:   w_rd_data = {24'd0, r_guard};
            8'h08:   w_rd_data = w_status;
            default: w_rd_data = 32'd0;
        endcase
    end

    // Decoded target from the SEL register; all-zero when disabled.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_onehot
            assign w_onehot[gi] = r_sel_en && (r_sel_idx == 5'(gi));
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_sel_en  <= 1'b0;
            r_sel_idx <= 5'd0;
            r_guard   <= RESET_GUARD;
            r_app_en  <= 1'b0;
            r_app_idx <= 5'd0;
            r_cnt     <= 8'd0;
            r_sw_cnt  <= 8'd0;
            r_active  <= 32'd0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
        end else begin
            r_ack  <= w_req;
            r_dat  <= (w_req && !wbs.wbs_we_i) ? w_rd_data : 32'd0;
            r_done <= 1'b0;

            if (w_sel_wr) begin
                r_sel_en  <= w_new_en;
                r_sel_idx <= w_new_idx;
            end
            if (w_guard_wr) begin
                r_guard <= w_new_guard;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_sel_wr && ({w_new_en, w_new_idx} != {r_app_en, r_app_idx})) begin
                        r_state  <= S_DRAIN;
                        r_active <= 32'd0;
                        r_cnt    <= r_guard;
                    end
                end
                S_DRAIN: begin
                    // A new selection restarts the full drain; the target is
                    // always read from SEL when the drain finishes.
                    if (w_sel_wr) begin
                        r_cnt <= r_guard;
                    end else if (r_cnt == 8'd0) begin
                        r_active  <= w_onehot;
                        r_app_en  <= r_sel_en;
                        r_app_idx <= r_sel_idx;
                        r_sw_cnt  <= r_sw_cnt + 8'd1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign switch_done   = r_done;

endmodule
